sram_load_ctrl: RTL and testbench

- Upstream loader stage for the dual-bank perip_SRAM pair.
- Accepts a 32-bit word stream over a valid/ready handshake and packs consecutive word pairs into 64-bit lines: first word goes to the low bank, second to the high bank.
- Writes each line to a sequential 19-bit SRAM address, holding the write mode for a fixed number of cycles.
- Drives SRAM_ADDR_Stream, SRAM_DATA_IN_Stream and mode_R1_W0 of the SRAM wrappers; on completion it releases them to read mode for the primitive-lookup path.

---
 rtl/sram_load_ctrl_if.sv | 22 ++
 rtl/sram_load_ctrl.sv | 153 +++++++++++++++
 tb/tb_sram_load_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_load_ctrl_if.sv
// Stream-in handshake plus the SRAM-facing address/data/mode bus of the loader.
interface sram_load_ctrl_if #(
  parameter int ADDRW = 19,
  parameter int DATAW = 32
);
  logic                 in_valid;
  logic [DATAW-1:0]     in_data;
  logic                 in_ready;
  logic [ADDRW-1:0]     SRAM_ADDR_Stream;
  logic [2*DATAW-1:0]   SRAM_DATA_IN_Stream;
  logic                 mode_R1_W0;

  modport master (
    output in_valid, in_data,
    input  in_ready, SRAM_ADDR_Stream, SRAM_DATA_IN_Stream, mode_R1_W0
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, SRAM_ADDR_Stream, SRAM_DATA_IN_Stream, mode_R1_W0
  );
endinterface

// File: rtl/sram_load_ctrl.sv
// Packs pairs of stream words into {high, low} lines and writes them to
// sequential SRAM addresses, holding write mode for WR_CYCLES per line.
module sram_load_ctrl #(
  parameter int          ADDRW     = 19,
  parameter int          DATAW     = 32,
  parameter int          WR_CYCLES = 2,
  parameter int unsigned LAST_ADDR = 2**19-1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             start,
  input  logic             abort,
  sram_load_ctrl_if.slave  bus,
  output logic             busy,
  output logic             done,
  output logic [ADDRW:0]   wr_count
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [ADDRW-1:0] LAST     = ADDRW'(LAST_ADDR);
  localparam logic [3:0]       CNT_INIT = 4'(WR_CYCLES - 1);
  localparam logic [ADDRW:0]   WR_MAX   = {1'b1, {ADDRW{1'b0}}};

  state_e               state_q, state_d;
  logic [ADDRW-1:0]     addr_q, addr_d;
  logic [2*DATAW-1:0]   data_q, data_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDRW:0]       wr_count_q, wr_count_d;
  logic                 mode_q, mode_d;
  logic                 pend_q, pend_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 rdy_q, rdy_d;
  logic                 xfer_s;
  logic                 reinit_s;

  assign xfer_s   = bus.in_valid && rdy_q;
  assign reinit_s = ((state_q == S_IDLE) || (state_q == S_DONE)) && (state_d == S_LOW);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= 4'd0;
      wr_count_q <= '0;
      mode_q     <= 1'b1;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      wr_count_q <= wr_count_d;
      mode_q     <= mode_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      rdy_q      <= rdy_d;
    end
  end

  // A pending abort never shortens a write; it only redirects the exit from WRITE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !abort) state_d = S_LOW; else state_d = S_IDLE;
      S_LOW:   if (abort) state_d = S_IDLE; else if (xfer_s) state_d = S_HIGH; else state_d = S_LOW;
      S_HIGH:  if (abort) state_d = S_IDLE; else if (xfer_s) state_d = S_WRITE; else state_d = S_HIGH;
      S_WRITE: begin
        if (cnt_q != 4'd0)            state_d = S_WRITE;
        else if (addr_q == LAST)      state_d = S_DONE;
        else if (pend_q || abort)     state_d = S_IDLE;
        else                          state_d = S_LOW;
      end
      S_DONE:  if (abort) state_d = S_IDLE; else if (start) state_d = S_LOW; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    wr_count_d = wr_count_q;
    mode_d     = mode_q;
    done_d     = done_q;
    case (state_q)
      S_LOW: begin
        if (state_d == S_HIGH) data_d[DATAW-1:0] = bus.in_data;
        else                   data_d = data_q;
      end
      S_HIGH: begin
        if (state_d == S_WRITE) begin
          data_d[2*DATAW-1:DATAW] = bus.in_data;
          mode_d                  = 1'b0;
          cnt_d                   = CNT_INIT;
        end else begin
          mode_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (cnt_q == 4'd0) begin
          mode_d = 1'b1;
          if (wr_count_q != WR_MAX) wr_count_d = wr_count_q + (ADDRW+1)'(1);
          else                      wr_count_d = wr_count_q;
          if (state_d == S_LOW)     addr_d = addr_q + ADDRW'(1);
          else                      addr_d = addr_q;
          if (state_d == S_DONE)    done_d = 1'b1;
          else                      done_d = done_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (state_d == S_IDLE) done_d = 1'b0;
        else                   done_d = done_q;
      end
      default: mode_d = 1'b1;
    endcase
    if (reinit_s) begin
      addr_d     = '0;
      wr_count_d = '0;
      done_d     = 1'b0;
    end else begin
      addr_d = addr_d;
    end
  end

  always_comb begin
    if ((state_q == S_WRITE) && (state_d == S_WRITE)) pend_d = pend_q || abort;
    else                                              pend_d = 1'b0;
    busy_d = state_d inside {S_LOW, S_HIGH, S_WRITE};
    rdy_d  = state_d inside {S_LOW, S_HIGH};
  end

  assign bus.in_ready            = rdy_q;
  assign bus.SRAM_ADDR_Stream    = addr_q;
  assign bus.SRAM_DATA_IN_Stream = data_q;
  assign bus.mode_R1_W0          = mode_q;
  assign busy                    = busy_q;
  assign done                    = done_q;
  assign wr_count                = wr_count_q;
endmodule

// File: tb/tb_sram_load_ctrl.sv
// Scoreboard bench: the driver queues expected line writes, a negedge monitor checks each SRAM write.
module tb_sram_load_ctrl;
  localparam int ADDRW     = 19;
  localparam int DATAW     = 32;
  localparam int WR_CYCLES = 2;
  localparam int LAST_ADDR = 3;

  typedef struct packed {
    logic [ADDRW-1:0]   addr;
    logic [2*DATAW-1:0] data;
  } line_t;

  logic             CLK;
  logic             RSTn;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic [ADDRW:0]   wr_count;

  int               vectors;
  int               miscompares;
  int               cyc;
  line_t            exp_q[$];
  line_t            last_line;
  logic [DATAW-1:0] lo_m;
  bit               have_lo;
  int               addr_m;
  int               lines_m;
  bit               expect_stop;
  int               low_len;
  logic [ADDRW-1:0] cur_addr;

  sram_load_ctrl_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  sram_load_ctrl #(
    .ADDRW(ADDRW), .DATAW(DATAW), .WR_CYCLES(WR_CYCLES), .LAST_ADDR(LAST_ADDR)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort), .bus(bus),
    .busy(busy), .done(done), .wr_count(wr_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each line write is matched against the oldest queued expectation on its first low-mode cycle.
  always @(negedge CLK) begin
    line_t e;
    if (bus.mode_R1_W0 === 1'b0) begin
      if (low_len == 0) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.SRAM_ADDR_Stream, bus.SRAM_DATA_IN_Stream);
        end else begin
          e = exp_q.pop_front();
          cur_addr = e.addr;
          check("wr_addr", bus.SRAM_ADDR_Stream, e.addr);
          check("wr_data", bus.SRAM_DATA_IN_Stream, e.data);
        end
      end else begin
        check("wr_addr_hold", bus.SRAM_ADDR_Stream, cur_addr);
      end
      check("rdy_in_write", bus.in_ready, 0);
      low_len++;
    end else begin
      if (low_len != 0) begin
        check("wr_len", low_len, WR_CYCLES);
        check("rdy_after_wr", bus.in_ready, (expect_stop || cur_addr == LAST_ADDR) ? 0 : 1);
        expect_stop = 1'b0;
      end
      low_len = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [DATAW-1:0] w);
    line_t l;
    if (!have_lo) begin
      lo_m    = w;
      have_lo = 1'b1;
    end else begin
      l.addr    = ADDRW'(addr_m);
      l.data    = {w, lo_m};
      last_line = l;
      exp_q.push_back(l);
      have_lo   = 1'b0;
      addr_m++;
      lines_m++;
    end
  endtask

  task automatic send_word(input logic [DATAW-1:0] w, input int gap);
    int t;
    bus.in_valid = 1'b0;
    if (gap > 0) tick(gap);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    t = 0;
    @(negedge CLK);
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: word %08h not taken, in_ready=%b expected 1", w, bus.in_ready);
    end
    tick(1);
    if (t < 50) accept(w);
    bus.in_valid = 1'b0;
  endtask

  task automatic start_load();
    start = 1'b1;
    tick(1);
    start   = 1'b0;
    have_lo = 1'b0;
    addr_m  = 0;
    lines_m = 0;
    check("start_busy", busy, 1);
    check("start_rdy", bus.in_ready, 1);
    check("start_done", done, 0);
    check("start_wrcnt", wr_count, 0);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 300) begin
      tick(1);
      t++;
    end
    check("done", done, 1);
    check("wr_count_done", wr_count, lines_m);
    check("addr_done", bus.SRAM_ADDR_Stream, LAST_ADDR);
    check("busy_done", busy, 0);
    check("mode_done", bus.mode_R1_W0, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_rdy", bus.in_ready, 0);
    check("rst_mode", bus.mode_R1_W0, 1);
    check("rst_addr", bus.SRAM_ADDR_Stream, 0);
    check("rst_data", bus.SRAM_DATA_IN_Stream, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wrcnt", wr_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vectors      = 0;
    miscompares  = 0;
    cyc          = 0;
    expect_stop  = 1'b0;
    low_len      = 0;
    cur_addr     = '0;
    have_lo      = 1'b0;
    addr_m       = 0;
    lines_m      = 0;
    RSTn         = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    tick(2);
    check_reset_vals();
    RSTn = 1'b1;
    tick(1);

    // Full load of the fixed word sequence, in_valid held high.
    start_load();
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send_word({8{4'(i)}}, 0);
    wait_done();
    check("load_cycles", cyc - c0, (LAST_ADDR + 1) * (WR_CYCLES + 2));
    tick(3);
    check("done_held", done, 1);

    // Backpressure with valid toggling 1,0,0,1, plus a start while busy.
    start_load();
    for (int i = 0; i < 8; i++) begin
      send_word($urandom, (i == 0) ? 0 : 2);
      if (i == 2) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_start_addr", bus.SRAM_ADDR_Stream, 1);
        check("busy_start_busy", busy, 1);
        check("busy_start_wrcnt", wr_count, 1);
        check("busy_start_rdy", bus.in_ready, 1);
      end
    end
    wait_done();

    // Abort during HIGH of line 1: partial line dropped.
    start_load();
    for (int i = 0; i < 3; i++) send_word($urandom, 0);
    abort = 1'b1;
    tick(1);
    abort   = 1'b0;
    have_lo = 1'b0;
    check("abort_hi_busy", busy, 0);
    check("abort_hi_rdy", bus.in_ready, 0);
    check("abort_hi_wrcnt", wr_count, lines_m);
    check("abort_hi_addr", bus.SRAM_ADDR_Stream, 1);
    check("abort_hi_mode", bus.mode_R1_W0, 1);
    tick(4);
    check("abort_hi_idle_mode", bus.mode_R1_W0, 1);
    check("abort_hi_idle_busy", busy, 0);

    // Abort in the first WRITE cycle of line 0: write completes, then IDLE.
    start_load();
    for (int i = 0; i < 2; i++) send_word($urandom, 0);
    abort       = 1'b1;
    expect_stop = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_wr_mode_low", bus.mode_R1_W0, 0);
    check("abort_wr_busy", busy, 1);
    tick(1);
    check("abort_wr_idle", busy, 0);
    check("abort_wr_rdy", bus.in_ready, 0);
    check("abort_wr_wrcnt", wr_count, 1);
    check("abort_wr_addr", bus.SRAM_ADDR_Stream, 0);
    check("abort_wr_data", bus.SRAM_DATA_IN_Stream, last_line.data);
    tick(3);
    check("abort_wr_stay", busy, 0);

    // Reset during the second WRITE cycle of line 2, then reload from 0.
    start_load();
    for (int i = 0; i < 6; i++) send_word($urandom, 0);
    tick(1);
    RSTn        = 1'b0;
    expect_stop = 1'b1;
    tick(1);
    RSTn    = 1'b1;
    have_lo = 1'b0;
    check_reset_vals();
    start_load();
    for (int i = 0; i < 8; i++) send_word($urandom, int'($urandom_range(0, 1)));
    wait_done();

    // start together with abort in IDLE.
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", busy, 0);
    check("sa_rdy", bus.in_ready, 0);
    tick(2);
    check("sa_busy_later", busy, 0);
    check("sa_mode", bus.mode_R1_W0, 1);
    check("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
